// File: rtl/lcd_pkg.sv
// lcd_ctrl shared types and constants.
// Build option: LCD_INIT_EN adds the power-on init sequence.
package lcd_pkg;

`ifdef LCD_INIT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_INIT
  } lcd_state_e;
  // 750000-cycle power-on wait needs 20 bits
  localparam int LCD_TMR_W = 20;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } lcd_state_e;
  localparam int LCD_TMR_W = 18;
`endif

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RS_BIT = 9;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;

  // clear/home (and 0x03) need the long execution wait
  function automatic logic is_slow(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == LCD_CMD_CLEAR ||
                   data == LCD_CMD_HOME  ||
                   data == 8'h03);
  endfunction

  function automatic logic [7:0] init_cmd(
    input logic [1:0] idx
  );
    logic [7:0] c;
    c = LCD_CMD_FUNC;
    unique case (idx)
      2'd0: c = LCD_CMD_FUNC;
      2'd1: c = LCD_CMD_DISP;
      2'd2: c = LCD_CMD_CLEAR;
      2'd3: c = LCD_CMD_ENTRY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_ctrl phase timer: loadable down-counter.
// Holds at zero; done while the count is zero.
module lcd_timer
  import lcd_pkg::*;
#(
  parameter int                W       = LCD_TMR_W,
  parameter logic [W-1:0]      RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins, otherwise count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_load)
      cnt_d = i_value;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 bus sequencer behind the LSU LCD register.
// Build option: LCD_INIT_EN runs the power-on init sequence.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 4,
  parameter int EN_HIGH_CYC   = 12,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int CLR_WAIT_CYC  = 82000,
  parameter int INIT_WAIT_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_reg,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_busy,
  output logic        o_lcd_ovf
);

  localparam int TW = LCD_TMR_W;
  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_PULSE = TW'(EN_HIGH_CYC - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] T_CMD   = TW'(CMD_WAIT_CYC - 1);
  localparam logic [TW-1:0] T_CLR   = TW'(CLR_WAIT_CYC - 1);
`ifdef LCD_INIT_EN
  localparam logic [TW-1:0] T_RST   = TW'(INIT_WAIT_CYC - 1);
  localparam lcd_state_e    S_RST   = S_INIT;
  localparam logic          B_RST   = 1'b1;
`else
  localparam logic [TW-1:0] T_RST   = '0;
  localparam lcd_state_e    S_RST   = S_IDLE;
  localparam logic          B_RST   = 1'b0;
`endif

  logic [31:0] reg_q;
  logic        en_d_q;
  lcd_state_e  state_q, state_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        pend_q, pend_d;
  logic        prs_q, prs_d;
  logic [7:0]  pdata_q, pdata_d;
  logic        ovf_q, ovf_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic [2:0]  init_q, init_d;
  logic        init_left;
  logic        req, accept;
  logic        ld, done;
  logic [TW-1:0] ld_val;
  logic        unused_bits;

  assign unused_bits = ^{reg_q[30:11], reg_q[8]};

  assign req = reg_q[LCD_EN_BIT] & ~en_d_q;

`ifdef LCD_INIT_EN
  assign init_left = (init_q != 3'd4);
`else
  assign init_left = 1'b0;
`endif

  lcd_timer #(.W(TW), .RST_VAL(T_RST)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ld),
    .i_value (ld_val),
    .o_done  (done)
  );

  // sequencer, pending slot and overflow tracking
  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pend_d  = pend_q;
    prs_d   = prs_q;
    pdata_d = pdata_q;
    ovf_d   = ovf_q;
    init_d  = init_q;
    accept  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (init_left) begin
          rs_d    = 1'b0;
          data_d  = init_cmd(init_q[1:0]);
          init_d  = init_q + 3'd1;
          state_d = S_SETUP;
        end else if (pend_q) begin
          rs_d    = prs_q;
          data_d  = pdata_q;
          pend_d  = 1'b0;
          state_d = S_SETUP;
        end else if (req) begin
          rs_d    = reg_q[LCD_RS_BIT];
          data_d  = reg_q[7:0];
          accept  = 1'b1;
          state_d = S_SETUP;
        end
        if (state_d == S_SETUP) begin
          ld     = 1'b1;
          ld_val = T_SETUP;
        end
      end
      S_SETUP: if (done) begin
        state_d = S_PULSE;
        ld      = 1'b1;
        ld_val  = T_PULSE;
      end
      S_PULSE: if (done) begin
        state_d = S_HOLD;
        ld      = 1'b1;
        ld_val  = T_HOLD;
      end
      S_HOLD: if (done) begin
        state_d = S_WAIT;
        ld      = 1'b1;
        ld_val  = is_slow(rs_q, data_q) ? T_CLR : T_CMD;
      end
      S_WAIT: if (done) state_d = S_IDLE;
`ifdef LCD_INIT_EN
      S_INIT: if (done) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    if (req && !accept) begin
      if (!pend_q) begin
        pend_d  = 1'b1;
        prs_d   = reg_q[LCD_RS_BIT];
        pdata_d = reg_q[7:0];
      end else begin
        ovf_d = 1'b1;
      end
    end
    en_d   = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE) | pend_d |
             (init_d != init_q) | init_left;
  end

  // input pipeline and controller state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reg_q   <= '0;
      en_d_q  <= 1'b0;
      state_q <= S_RST;
      rs_q    <= 1'b0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      prs_q   <= 1'b0;
      pdata_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= B_RST;
      init_q  <= 3'd0;
    end else begin
      reg_q   <= i_lcd_reg;
      en_d_q  <= reg_q[LCD_EN_BIT];
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      prs_q   <= prs_d;
      pdata_q <= pdata_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
    end
  end

`ifndef LCD_INIT_EN
  logic unused_init;
  assign unused_init = ^init_q;
`endif

  assign o_lcd_on   = reg_q[LCD_ON_BIT];
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_lcd_busy = busy_q;
  assign o_lcd_ovf  = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl (default build).
// Edge counts are negedge indices from the first write.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lcd_reg = '0;
  logic        on, en, rs, rw, busy, ovf;
  logic [7:0]  data;

  int n_chk = 0;
  int n_err = 0;

  int pulses;
  int busy_low;
  int rise_at [4];
  int width   [4];
  logic [7:0] dat [4];
  logic       rsv [4];

  always #5 clk = ~clk;

  lcd_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_lcd_reg  (lcd_reg),
    .o_lcd_on   (on),
    .o_lcd_en   (en),
    .o_lcd_rs   (rs),
    .o_lcd_rw   (rw),
    .o_lcd_data (data),
    .o_lcd_busy (busy),
    .o_lcd_ovf  (ovf)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] w);
    lcd_reg = w;
    @(negedge clk);
  endtask

  // observe EN pulses until busy falls or the budget ends
  task automatic watch(input int start, input int max);
    logic prev;
    logic seen;
    prev = 1'b0;
    seen = 1'b0;
    pulses = 0;
    busy_low = -1;
    for (int i = 0; i < 4; i++) begin
      rise_at[i] = -1;
      width[i] = 0;
      dat[i] = '0;
      rsv[i] = 1'b0;
    end
    for (int t = start; t < max; t++) begin
      @(negedge clk);
      if (en && !prev) begin
        if (pulses < 4) begin
          rise_at[pulses] = t;
          dat[pulses] = data;
          rsv[pulses] = rs;
        end
        pulses++;
      end
      if (en && pulses >= 1 && pulses <= 4)
        width[pulses-1]++;
      if (busy) seen = 1'b1;
      else if (seen) begin
        busy_low = t;
        break;
      end
      prev = en;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_on", on, 0);
    chk("rst_en", en, 0);
    chk("rst_rs", rs, 0);
    chk("rst_rw", rw, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);

    put(32'h8000_0641);
    lcd_reg = 32'h8000_0241;
    watch(2, 3000);
    chk("a_on", on, 1);
    chk("a_pulses", pulses, 1);
    chk("a_rise", rise_at[0], 6);
    chk("a_width", width[0], 12);
    chk("a_rs", rsv[0], 1);
    chk("a_data", dat[0], 8'h41);
    chk("a_busy_low", busy_low, 2020);
    chk("a_rw", rw, 0);

    put(32'h0000_0401);
    lcd_reg = 32'h0000_0001;
    watch(2, 83000);
    chk("clr_on", on, 0);
    chk("clr_rise", rise_at[0], 6);
    chk("clr_rs", rsv[0], 0);
    chk("clr_data", dat[0], 8'h01);
    chk("clr_busy_low", busy_low, 82020);

    put(32'h8000_0431);
    put(32'h8000_0031);
    put(32'h8000_0432);
    put(32'h8000_0032);
    put(32'h8000_0433);
    lcd_reg = 32'h8000_0033;
    watch(6, 5000);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_d0", dat[0], 8'h31);
    chk("b2b_d1", dat[1], 8'h32);
    chk("b2b_rise0", rise_at[0], 6);
    chk("b2b_gap", rise_at[1] - rise_at[0] - width[0], 2007);
    chk("b2b_w1", width[1], 12);
    chk("b2b_busy_low", busy_low, 4039);
    repeat (5) @(negedge clk);
    chk("b2b_ovf", ovf, 1);

    put(32'h8000_0655);
    put(32'h8000_0255);
    put(32'h8000_0656);
    lcd_reg = 32'h8000_0256;
    n = 0;
    while (!en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_en_seen", en, 1);
    chk("ar_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("ar_en", en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_data", data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    watch(0, 200);
    chk("ar_pulses", pulses, 0);
    chk("ar_busy_post", busy, 0);
    chk("ar_on", on, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- HD44780 character-LCD bus sequencer, directly downstream of the LSU's memory-mapped LCD register output (o_io_lcd).
- Software writes a command/data word with the EN bit set. This block turns each rising EN request into a correctly timed LCD bus cycle (setup, enable pulse, hold, execution wait).
- It reports busy status back for the LSU read path.

Parameters:
- SETUP_CYC, 4, cycles RS/DATA are stable before EN rises (tAS)
- EN_HIGH_CYC, 12, cycles EN is held high (≥230 ns at 50 MHz)
- HOLD_CYC, 2, cycles RS/DATA are held after EN falls
- CMD_WAIT_CYC, 2000, execution wait for normal commands and data (40 us)
- CLR_WAIT_CYC, 82000, execution wait for clear/home commands (1.64 ms)
- INIT_WAIT_CYC, 750000, power-on wait, used only with LCD_INIT_EN (15 ms)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_lcd_reg  in  32  LSU LCD register: [31]=ON, [10]=EN request, [9]=RS, [8]=RW (ignored), [7:0]=DATA
- o_lcd_on  out  1  panel power/backlight enable
- o_lcd_en  out  1  LCD EN pin
- o_lcd_rs  out  1  LCD RS pin
- o_lcd_rw  out  1  LCD RW pin, always 0
- o_lcd_data  out  8  LCD DB[7:0]
- o_lcd_busy  out  1  1 while a command is in flight or pending
- o_lcd_ovf  out  1  sticky: a request was dropped

Behaviour:
- Input handling:
  - i_lcd_reg is registered into r_reg every cycle.
  - r_en_d <= r_reg[10].
  - req = r_reg[10] & ~r_en_d.
  - Both registers reset to 0, so if bit10 is held high when reset is released, exactly one request is generated.
- Reset values: all outputs 0; state IDLE; pending buffer empty; timer 0.
- o_lcd_on = r_reg[31]. Latency is 1 cycle after i_lcd_reg. It is independent of the FSM.
- Request capture: on req, {RS, DATA} is copied from r_reg.
  - In IDLE with pending empty: the FSM goes straight to SETUP.
  - Otherwise, if pending is empty: the request is stored in pending.
  - Otherwise (pending full): the request is dropped and o_lcd_ovf <= 1. o_lcd_ovf clears only on reset.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT (plus INIT states when enabled).
  - IDLE: if pending is full, pop pending into the active registers and go to SETUP. Else, on req, go to SETUP.
  - SETUP: o_lcd_rs/o_lcd_data drive the active command from the first SETUP cycle. After SETUP_CYC cycles, go to PULSE.
  - PULSE: o_lcd_en=1 for exactly EN_HIGH_CYC cycles, then go to HOLD.
  - HOLD: o_lcd_en=0, RS/DATA unchanged, for HOLD_CYC cycles, then go to WAIT.
  - WAIT: lasts CLR_WAIT_CYC if RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise CMD_WAIT_CYC. Then go to IDLE.
- RS/DATA keep their last values in IDLE. They are not cleared.
- o_lcd_busy = (state != IDLE) | pending_full. It is registered, so it asserts the cycle after req is seen.
- Request latency: from the req cycle to the first o_lcd_en=1 is 1+SETUP_CYC cycles.
- Back-to-back handling: a request popped from pending enters SETUP on the cycle after WAIT→IDLE. Exactly one IDLE cycle separates consecutive commands.
- Asynchronous reset mid-operation aborts the cycle immediately: o_lcd_en drops to 0 and pending is discarded.
- Timer rule: a single down-counter is loaded with (N-1) on state entry. The state is left when the count reaches 0. Parameters must be ≥1.

Optional Feature:
- LCD_INIT_EN defined:
  - After reset, the FSM runs INIT_WAIT for INIT_WAIT_CYC cycles.
  - It then issues RS=0 commands 0x38, 0x0C, 0x01, 0x06 in order, each using the full SETUP/PULSE/HOLD/WAIT sequence.
  - o_lcd_busy=1 throughout. User requests arriving during init go to pending under the normal overflow rules.
- LCD_INIT_EN undefined: the FSM starts in IDLE and no init states exist.

Decomposition:
- Package lcd_pkg:
  - State enum lcd_state_e.
  - Bit-position constants LCD_ON_BIT=31, LCD_EN_BIT=10, LCD_RS_BIT=9.
  - Command constants LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, and the four init-sequence bytes.
- Sub-module lcd_timer: 18-bit loadable down-counter with load/value/done ports, instantiated once.

Test Plan:
- Reset released with i_lcd_reg=0 → all outputs 0, busy=0, ovf=0.
- Write 32'h8000_0641 (ON, EN, RS, 'A'), then clear EN →
  - o_lcd_on=1.
  - rs=1, data=0x41.
  - en high for exactly 12 cycles, starting 5 cycles after req.
  - busy low after 4+12+2+2000 cycles, plus the 2-cycle input pipeline.
- Write EN with RS=0, DATA=0x01 → WAIT lasts 82000 cycles; busy stays high throughout.
- Three EN rising edges (data 0x31, 0x32, 0x33) within 50 cycles →
  - 0x31 and 0x32 are sent in order, separated by one IDLE cycle.
  - 0x33 is dropped and ovf=1 until reset.
- Assert i_rst during PULSE → en=0 immediately; busy=0; pending is lost; no further EN pulse.
- With LCD_INIT_EN: after reset, no EN pulse for 750000 cycles, then exactly four pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0.
